// File: rtl/data_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_port_if
// Brief   : Pipeline/RAM bus bundle for data_mem_port (master = pipeline + RAM,
//           slave = data_mem_port). align_fault exists only with
//           DATA_MEM_ALIGN_CHECK_EN defined.
// Revision: 1.0
// ============================================================================
interface data_mem_port_if #(
   parameter int ADDR_W = 6
);
   logic              req_valid;
   logic [5:0]        op_code;
   logic [31:0]       target_mem_addr;
   logic [31:0]       store_data;
   logic [31:0]       mem_rdata;
   logic [ADDR_W-1:0] mem_address;
   logic [31:0]       mem_wdata;
   logic [3:0]        byte_enable;
   logic              mem_we;
   logic              mem_re;
   logic [31:0]       load_data;
   logic              load_valid;
   logic              stall;
`ifdef DATA_MEM_ALIGN_CHECK_EN
   logic              align_fault;
`endif

   modport master (
      output req_valid, op_code, target_mem_addr, store_data, mem_rdata,
      input  mem_address, mem_wdata, byte_enable, mem_we, mem_re,
             load_data, load_valid, stall
`ifdef DATA_MEM_ALIGN_CHECK_EN
      , input align_fault
`endif
   );

   modport slave (
      input  req_valid, op_code, target_mem_addr, store_data, mem_rdata,
      output mem_address, mem_wdata, byte_enable, mem_we, mem_re,
             load_data, load_valid, stall
`ifdef DATA_MEM_ALIGN_CHECK_EN
      , output align_fault
`endif
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_port
// Brief   : Memory-stage load/store controller for a word-addressed data RAM.
//           Define DATA_MEM_ALIGN_CHECK_EN to add the align_fault output.
// Revision: 1.0
// ============================================================================
module data_mem_port #(
   parameter int ADDR_W   = 6,
   parameter int READ_LAT = 1
) (
   input  wire logic      clk,
   input  wire logic      rst,
   data_mem_port_if.slave bus
);
   localparam logic [5:0] c_OP_LB  = 6'h20;
   localparam logic [5:0] c_OP_LH  = 6'h21;
   localparam logic [5:0] c_OP_LW  = 6'h23;
   localparam logic [5:0] c_OP_LBU = 6'h24;
   localparam logic [5:0] c_OP_LHU = 6'h25;
   localparam logic [5:0] c_OP_SB  = 6'h28;
   localparam logic [5:0] c_OP_SH  = 6'h29;
   localparam logic [5:0] c_OP_SW  = 6'h2B;
   localparam int         c_CNT_W  = 3;

   localparam logic [1:0] c_SZ_BYTE = 2'd0;
   localparam logic [1:0] c_SZ_HALF = 2'd1;
   localparam logic [1:0] c_SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_WAIT = 2'd1,
      S_RD_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [1:0]          r_lane;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         r_load_data;
   logic [3:0]          r_be;
   logic                r_we;
   logic                r_re;
   logic                r_load_valid;

   logic                w_is_load;
   logic                w_is_store;
   logic [1:0]          w_size;
   logic [1:0]          w_off;
   logic [3:0]          w_be;
   logic [31:0]         w_wdata;
   logic                w_fault;
   logic                w_accept;
   logic [ADDR_W-1:0]   w_word_addr;
   logic                w_unused_addr;

   assign w_off         = bus.target_mem_addr[1:0];
   assign w_word_addr   = bus.target_mem_addr[ADDR_W+1:2];
   // Upper address bits wrap modulo the RAM size.
   assign w_unused_addr = ^bus.target_mem_addr[31:ADDR_W+2];

   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_size     = c_SZ_BYTE;
      case (bus.op_code)
         c_OP_LB, c_OP_LBU: begin w_is_load  = 1'b1; w_size = c_SZ_BYTE; end
         c_OP_LH, c_OP_LHU: begin w_is_load  = 1'b1; w_size = c_SZ_HALF; end
         c_OP_LW:           begin w_is_load  = 1'b1; w_size = c_SZ_WORD; end
         c_OP_SB:           begin w_is_store = 1'b1; w_size = c_SZ_BYTE; end
         c_OP_SH:           begin w_is_store = 1'b1; w_size = c_SZ_HALF; end
         c_OP_SW:           begin w_is_store = 1'b1; w_size = c_SZ_WORD; end
         default:           ;
      endcase
   end

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = bus.store_data;
      case (w_size)
         c_SZ_BYTE: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{bus.store_data[7:0]}};
         end
         c_SZ_HALF: begin
            w_be    = w_off[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{bus.store_data[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef DATA_MEM_ALIGN_CHECK_EN
   logic r_align_fault;
   assign w_fault = (w_is_load | w_is_store) &
                    (((w_size == c_SZ_HALF) & w_off[0]) |
                     ((w_size == c_SZ_WORD) & (w_off != 2'b00)));
   assign bus.align_fault = r_align_fault;
`else
   assign w_fault = 1'b0;
`endif

   assign w_accept  = (r_state == S_IDLE) & bus.req_valid & ~w_fault;
   // Stall rises combinationally in the accept cycle so upstream holds.
   assign bus.stall = (w_accept & w_is_load) | (r_state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_lane       <= 2'b00;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_load_data  <= '0;
         r_be         <= 4'b0000;
         r_we         <= 1'b0;
         r_re         <= 1'b0;
         r_load_valid <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
         r_align_fault <= 1'b0;
`endif
      end else begin
         r_we         <= 1'b0;
         r_re         <= 1'b0;
         r_be         <= 4'b0000;
         r_load_valid <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
         r_align_fault <= (r_state == S_IDLE) & bus.req_valid & w_fault;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_accept && w_is_store) begin
                  r_we    <= 1'b1;
                  r_addr  <= w_word_addr;
                  r_wdata <= w_wdata;
                  r_be    <= w_be;
               end else if (w_accept && w_is_load) begin
                  r_re    <= 1'b1;
                  r_addr  <= w_word_addr;
                  r_lane  <= w_off;
                  r_cnt   <= c_CNT_W'(READ_LAT);
                  r_state <= S_RD_WAIT;
               end
            end
            S_RD_WAIT: begin
               if (r_cnt == c_CNT_W'(1)) begin
                  r_load_data  <= bus.mem_rdata >> {r_lane, 3'b000};
                  r_load_valid <= 1'b1;
                  r_cnt        <= '0;
                  r_state      <= S_RD_DONE;
               end else begin
                  r_cnt <= r_cnt - c_CNT_W'(1);
               end
            end
            S_RD_DONE: r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_address = r_addr;
   assign bus.mem_wdata   = r_wdata;
   assign bus.byte_enable = r_be;
   assign bus.mem_we      = r_we;
   assign bus.mem_re      = r_re;
   assign bus.load_data   = r_load_data;
   assign bus.load_valid  = r_load_valid;
endmodule
`default_nettype wire
